clint_trap: RTL and testbench
=============================

// Module: clint_trap
// PURPOSE
//  Core-local trap sequencer; sits between the decode/execute stage and the CSR register file,
//    driving its clint_* port.
//  Detects ecall, ebreak and mret, plus an external machine interrupt.
//  Saves mepc/mcause through the single CSR write port, reads mtvec or mepc back, and redirects the PC.
//  Holds the pipeline while a trap sequence runs.
// PARAMETERS
//  CAUSE_ECALL   32'd11          mcause value for ecall
//  CAUSE_EBREAK  32'd3           mcause value for ebreak
//  CAUSE_IRQ     32'h8000000B    mcause value for the machine external interrupt
// PORTS
//  clk            in   1   core clock
//  rst            in   1   asynchronous, active-high reset
//  ecall_i        in   1   ecall in execute this cycle (1-cycle pulse)
//  ebreak_i       in   1   ebreak in execute this cycle (1-cycle pulse)
//  mret_i         in   1   mret in execute this cycle (1-cycle pulse)
//  irq_i          in   1   external interrupt request (level)
//  inst_addr_i    in   32  address of the instruction currently in execute
//  ex_csr_we_i    in   1   execute stage is writing a CSR (it has priority on the write port)
//  csr_data_i     in   32  combinational read data from the CSR file (clint read port)
//  csr_raddr_o    out  32  CSR read address
//  csr_we_o       out  1   CSR write enable
//  csr_waddr_o    out  32  CSR write address (0x341 mepc, 0x342 mcause)
//  csr_wdata_o    out  32  CSR write data
//  hold_o         out  1   stall fetch/decode/execute
//  jump_o         out  1   PC redirect strobe (1 cycle)
//  jump_addr_o    out  32  PC redirect target
//  busy_o         out  1   state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, in_trap=0; all outputs 0; latched epc/cause 0.
//    Reset asserted mid-sequence aborts immediately with no further CSR writes.
//  States:
//    IDLE -> MEPC   (ecall | ebreak | irq accepted)
//    IDLE -> MRET   (mret)
//    MEPC -> MCAUSE
//    MCAUSE -> JUMP
//    JUMP -> IDLE
//    MRET -> IDLE
//  Acceptance (IDLE only), priority order:
//    ecall > ebreak > mret > irq.
//    irq is accepted only when in_trap=0; it stays level-sensitive and is simply re-sampled while masked.
//  Acceptance cycle T:
//    latch epc=inst_addr_i and cause (CAUSE_ECALL / CAUSE_EBREAK / CAUSE_IRQ).
//    hold_o=1 combinationally in T.
//    hold_o stays 1 while state is MEPC, MCAUSE, JUMP or MRET.
//  MEPC:   csr_we_o=1, waddr=0x341, wdata=epc.
//  MCAUSE: csr_we_o=1, waddr=0x342, wdata=cause.
//  Write port contention: if ex_csr_we_i=1 while in MEPC or MCAUSE, the CSR file drops our write.
//    The FSM therefore stays in that state and retries next cycle; csr_we_o is still driven.
//  JUMP:
//    csr_raddr_o=0x305; jump_o=1; jump_addr_o=csr_data_i (mtvec).
//    Sets in_trap=1 if cause=CAUSE_IRQ.
//  MRET:
//    csr_raddr_o=0x341; jump_o=1; jump_addr_o=csr_data_i (mepc).
//    Clears in_trap.
//  Nominal latency with no contention:
//    trap: jump_o at T+3, hold released at T+4.
//    mret: jump_o at T+1.
//  Events that arrive while not in IDLE are ignored; the pipeline is held, so sync events cannot arrive then.
//  csr_raddr_o=0 and jump_addr_o=0 whenever they are not in use.
//  The mtvec read is combinational in the same cycle as the jump; csr_data_i must be stable by the edge.
// TESTING
//  1. ecall_i pulse, inst_addr_i=0x100, mtvec=0x200 -> mepc=0x100 (T+1), mcause=11 (T+2),
//     jump_o with addr 0x200 at T+3; hold_o high T..T+3.
//  2. irq_i=1, in_trap=0, inst_addr_i=0x44 -> mcause=0x8000000B, jump to mtvec, in_trap=1;
//     irq_i kept high -> no second entry until mret.
//  3. mret_i after test 2 with mepc=0x44 -> jump_o at T+1 to 0x44, in_trap=0; pending irq re-enters at the next IDLE.
//  4. ex_csr_we_i=1 for 2 cycles during MEPC -> MEPC held 3 cycles, then the sequence completes;
//     final mepc/mcause correct, jump at T+5.
//  5. ecall_i and irq_i in the same cycle -> cause=11 is taken; irq is ignored because it is not yet in_trap-masked
//     but the FSM is busy; irq is taken only after JUMP if in_trap=0.
//  6. rst asserted in MCAUSE -> outputs 0 asynchronously, state=IDLE, mcause unwritten;
//     after release, a fresh ebreak completes normally with cause 3.

Source files
------------

// File: rtl/clint_trap.sv
// Trap sequencer: ecall/ebreak/irq save mepc then mcause and jump to mtvec (jump at T+3); mret jumps to mepc (T+1).
// A concurrent execute-stage CSR write wins the port; the save step then repeats while the pipeline stays held.
module clint_trap #(
  parameter logic [31:0] CAUSE_ECALL  = 32'd11,
  parameter logic [31:0] CAUSE_EBREAK = 32'd3,
  parameter logic [31:0] CAUSE_IRQ    = 32'h8000000B
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ecall_i,
  input  logic        ebreak_i,
  input  logic        mret_i,
  input  logic        irq_i,
  input  logic [31:0] inst_addr_i,
  input  logic        ex_csr_we_i,
  input  logic [31:0] csr_data_i,
  output logic [31:0] csr_raddr_o,
  output logic        csr_we_o,
  output logic [31:0] csr_waddr_o,
  output logic [31:0] csr_wdata_o,
  output logic        hold_o,
  output logic        jump_o,
  output logic [31:0] jump_addr_o,
  output logic        busy_o
);

  localparam logic [31:0] CSR_MTVEC  = 32'h305;
  localparam logic [31:0] CSR_MEPC   = 32'h341;
  localparam logic [31:0] CSR_MCAUSE = 32'h342;

  typedef enum logic [2:0] {IDLE, MEPC, MCAUSE, JUMP, MRET} state_t;

  state_t      state, state_nxt;
  logic        in_trap;
  logic [31:0] epc, cause;
  logic        take_trap, take_mret;
  logic [31:0] take_cause;

  // Acceptance priority: ecall > ebreak > mret > unmasked irq.
  always_comb begin
    take_trap  = 1'b0;
    take_mret  = 1'b0;
    take_cause = 32'h0;
    if (ecall_i) begin
      take_trap  = 1'b1;
      take_cause = CAUSE_ECALL;
    end else if (ebreak_i) begin
      take_trap  = 1'b1;
      take_cause = CAUSE_EBREAK;
    end else if (mret_i) begin
      take_mret  = 1'b1;
    end else if (irq_i && !in_trap) begin
      take_trap  = 1'b1;
      take_cause = CAUSE_IRQ;
    end
  end

  always_comb begin
    state_nxt   = state;
    csr_raddr_o = 32'h0;
    csr_we_o    = 1'b0;
    csr_waddr_o = 32'h0;
    csr_wdata_o = 32'h0;
    hold_o      = 1'b0;
    jump_o      = 1'b0;
    jump_addr_o = 32'h0;
    case (state)
      IDLE: begin
        hold_o = !rst && (take_trap || take_mret);
        if (take_trap)      state_nxt = MEPC;
        else if (take_mret) state_nxt = MRET;
      end
      MEPC: begin
        hold_o      = 1'b1;
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MEPC;
        csr_wdata_o = epc;
        if (!ex_csr_we_i) state_nxt = MCAUSE;
      end
      MCAUSE: begin
        hold_o      = 1'b1;
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MCAUSE;
        csr_wdata_o = cause;
        if (!ex_csr_we_i) state_nxt = JUMP;
      end
      JUMP: begin
        hold_o      = 1'b1;
        csr_raddr_o = CSR_MTVEC;
        jump_o      = 1'b1;
        jump_addr_o = csr_data_i;
        state_nxt   = IDLE;
      end
      MRET: begin
        hold_o      = 1'b1;
        csr_raddr_o = CSR_MEPC;
        jump_o      = 1'b1;
        jump_addr_o = csr_data_i;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy_o = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      in_trap <= 1'b0;
      epc     <= 32'h0;
      cause   <= 32'h0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && take_trap) begin
        epc   <= inst_addr_i;
        cause <= take_cause;
      end
      if (state == JUMP && cause == CAUSE_IRQ) in_trap <= 1'b1;
      if (state == MRET)                       in_trap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_clint_trap.sv
// Bench for clint_trap: directed scenarios with literal expectations, then randomized traffic against an operation-queue model.
module tb_clint_trap;

  logic        clk = 1'b0;
  logic        rst;
  logic        ecall, ebreak, mret, irq, ex_we;
  logic [31:0] inst_addr, csr_data;
  logic [31:0] csr_raddr, csr_waddr, csr_wdata, jump_addr;
  logic        csr_we, hold, jump, busy;

  localparam logic [31:0] C_IRQ = 32'h8000000B;

  clint_trap dut (
    .clk(clk), .rst(rst), .ecall_i(ecall), .ebreak_i(ebreak), .mret_i(mret), .irq_i(irq),
    .inst_addr_i(inst_addr), .ex_csr_we_i(ex_we), .csr_data_i(csr_data),
    .csr_raddr_o(csr_raddr), .csr_we_o(csr_we), .csr_waddr_o(csr_waddr), .csr_wdata_o(csr_wdata),
    .hold_o(hold), .jump_o(jump), .jump_addr_o(jump_addr), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // CSR file stand-in; execute-stage writes win the port and target unrelated CSRs.
  logic [31:0] mtvec, csr_mepc, csr_mcause;
  initial begin
    csr_mepc   = 32'h0;
    csr_mcause = 32'h0;
  end
  assign csr_data = (csr_raddr == 32'h305) ? mtvec :
                    (csr_raddr == 32'h341) ? csr_mepc : 32'h0;
  always @(posedge clk) begin
    if (!rst && csr_we && !ex_we) begin
      if (csr_waddr == 32'h341)      csr_mepc   <= csr_wdata;
      else if (csr_waddr == 32'h342) csr_mcause <= csr_wdata;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a trap is a queue of port operations; writes retire only when the port is free.
  typedef struct packed {
    logic [1:0]  kind;     // 0 write, 1 trap jump, 2 mret jump
    logic [31:0] addr;
    logic [31:0] data;
    logic        set_trap;
  } op_t;

  op_t         q[$];
  bit          m_in_trap = 1'b0;
  logic [31:0] m_mepc = 32'h0, m_mcause = 32'h0;
  logic [31:0] e_raddr, e_waddr, e_wdata, e_jaddr, m_cause;
  logic        e_we, e_hold, e_jump, e_busy, m_take;

  always @(negedge clk) begin
    e_raddr = 0; e_waddr = 0; e_wdata = 0; e_jaddr = 0;
    e_we = 0; e_hold = 0; e_jump = 0; e_busy = 0;
    if (!rst) begin
      if (q.size() != 0) begin
        e_hold = 1; e_busy = 1;
        if (q[0].kind == 2'd0) begin
          e_we = 1; e_waddr = q[0].addr; e_wdata = q[0].data;
        end else begin
          e_jump  = 1;
          e_raddr = q[0].addr;
          e_jaddr = (q[0].kind == 2'd1) ? mtvec : m_mepc;
        end
      end else begin
        e_hold = ecall || ebreak || mret || (irq && !m_in_trap);
      end
    end
    chk("csr_raddr", csr_raddr, e_raddr);
    chk("csr_we", {31'h0, csr_we}, {31'h0, e_we});
    chk("csr_waddr", csr_waddr, e_waddr);
    chk("csr_wdata", csr_wdata, e_wdata);
    chk("hold", {31'h0, hold}, {31'h0, e_hold});
    chk("jump", {31'h0, jump}, {31'h0, e_jump});
    chk("jump_addr", jump_addr, e_jaddr);
    chk("busy", {31'h0, busy}, {31'h0, e_busy});
    chk("mepc_csr", csr_mepc, m_mepc);
    chk("mcause_csr", csr_mcause, m_mcause);

    if (rst) begin
      q.delete();
      m_in_trap = 1'b0;
    end else if (q.size() != 0) begin
      if (q[0].kind == 2'd0) begin
        if (!ex_we) begin
          if (q[0].addr == 32'h341) m_mepc = q[0].data;
          else                      m_mcause = q[0].data;
          void'(q.pop_front());
        end
      end else begin
        if (q[0].kind == 2'd2)   m_in_trap = 1'b0;
        else if (q[0].set_trap)  m_in_trap = 1'b1;
        void'(q.pop_front());
      end
    end else begin
      m_take  = 1'b1;
      m_cause = 32'h0;
      if (ecall)                     m_cause = 32'd11;
      else if (ebreak)               m_cause = 32'd3;
      else if (mret) begin
        m_take = 1'b0;
        q.push_back('{kind: 2'd2, addr: 32'h341, data: 32'h0, set_trap: 1'b0});
      end else if (irq && !m_in_trap) m_cause = C_IRQ;
      else                           m_take = 1'b0;
      if (m_take) begin
        q.push_back('{kind: 2'd0, addr: 32'h341, data: inst_addr, set_trap: 1'b0});
        q.push_back('{kind: 2'd0, addr: 32'h342, data: m_cause, set_trap: 1'b0});
        q.push_back('{kind: 2'd1, addr: 32'h305, data: 32'h0, set_trap: (m_cause == C_IRQ)});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; ecall = 0; ebreak = 0; mret = 0; irq = 0; ex_we = 0;
    inst_addr = 0; mtvec = 32'h200;
    tick; #1;
    chk("rst hold", {31'h0, hold}, 32'h0);
    chk("rst busy", {31'h0, busy}, 32'h0);
    chk("rst jump", {31'h0, jump}, 32'h0);
    chk("rst we", {31'h0, csr_we}, 32'h0);
    tick; rst = 0;
    tick;

    // ecall at 0x100
    inst_addr = 32'h100; ecall = 1; #1;
    chk("t1 hold T", {31'h0, hold}, 32'h1);
    chk("t1 busy T", {31'h0, busy}, 32'h0);
    tick; ecall = 0; #1;
    chk("t1 mepc we", {31'h0, csr_we}, 32'h1);
    chk("t1 mepc addr", csr_waddr, 32'h341);
    chk("t1 mepc data", csr_wdata, 32'h100);
    tick; #1;
    chk("t1 mcause addr", csr_waddr, 32'h342);
    chk("t1 mcause data", csr_wdata, 32'd11);
    chk("t1 mepc csr", csr_mepc, 32'h100);
    tick; #1;
    chk("t1 jump", {31'h0, jump}, 32'h1);
    chk("t1 jump addr", jump_addr, 32'h200);
    chk("t1 raddr", csr_raddr, 32'h305);
    chk("t1 mcause csr", csr_mcause, 32'd11);
    tick; #1;
    chk("t1 hold released", {31'h0, hold}, 32'h0);
    chk("t1 raddr idle", csr_raddr, 32'h0);

    // irq at 0x44, then masked while held high
    inst_addr = 32'h44; irq = 1; #1;
    chk("t2 hold T", {31'h0, hold}, 32'h1);
    tick; tick; tick; #1;
    chk("t2 jump addr", jump_addr, 32'h200);
    chk("t2 mcause csr", csr_mcause, C_IRQ);
    chk("t2 mepc csr", csr_mepc, 32'h44);
    tick; #1;
    chk("t2 masked hold", {31'h0, hold}, 32'h0);
    tick; #1;
    chk("t2 masked busy", {31'h0, busy}, 32'h0);

    // mret returns to 0x44, pending irq re-enters
    mret = 1; #1;
    chk("t3 hold T", {31'h0, hold}, 32'h1);
    tick; mret = 0; #1;
    chk("t3 jump", {31'h0, jump}, 32'h1);
    chk("t3 jump addr", jump_addr, 32'h44);
    chk("t3 raddr", csr_raddr, 32'h341);
    tick; #1;
    chk("t3 irq reentry", {31'h0, hold}, 32'h1);
    tick; irq = 0;
    tick; tick; tick;
    mret = 1; tick; mret = 0; tick;

    // contention: port lost for two cycles in MEPC
    inst_addr = 32'h300; ecall = 1;
    tick; ecall = 0; ex_we = 1; #1;
    chk("t4 mepc 1", csr_waddr, 32'h341);
    tick; #1;
    chk("t4 mepc 2", csr_waddr, 32'h341);
    tick; ex_we = 0; #1;
    chk("t4 mepc 3", csr_waddr, 32'h341);
    tick; #1;
    chk("t4 mcause", csr_waddr, 32'h342);
    chk("t4 mepc csr", csr_mepc, 32'h300);
    tick; #1;
    chk("t4 jump T+5", {31'h0, jump}, 32'h1);
    tick;

    // ecall and irq together
    inst_addr = 32'h500; ecall = 1; irq = 1;
    tick; ecall = 0; tick; tick; #1;
    chk("t5 jump", {31'h0, jump}, 32'h1);
    chk("t5 mcause csr", csr_mcause, 32'd11);
    tick; #1;
    chk("t5 irq after", {31'h0, hold}, 32'h1);
    chk("t5 idle busy", {31'h0, busy}, 32'h0);
    tick; tick; tick; #1;
    chk("t5 irq jump", {31'h0, jump}, 32'h1);
    chk("t5 irq cause", csr_mcause, C_IRQ);
    irq = 0;
    tick; mret = 1; tick; mret = 0; tick;

    // reset during MCAUSE
    inst_addr = 32'h600; ebreak = 1;
    tick; ebreak = 0; tick; #1;
    chk("t6 in mcause", csr_waddr, 32'h342);
    #1; rst = 1; #1;
    chk("t6 rst we", {31'h0, csr_we}, 32'h0);
    chk("t6 rst hold", {31'h0, hold}, 32'h0);
    chk("t6 rst busy", {31'h0, busy}, 32'h0);
    chk("t6 rst waddr", csr_waddr, 32'h0);
    tick; rst = 0; #1;
    chk("t6 mcause kept", csr_mcause, C_IRQ);
    tick;
    inst_addr = 32'h700; ebreak = 1;
    tick; ebreak = 0; tick; tick; #1;
    chk("t6 jump", {31'h0, jump}, 32'h1);
    chk("t6 cause 3", csr_mcause, 32'd3);
    chk("t6 mepc", csr_mepc, 32'h700);
    tick;

    // randomized traffic
    mtvec = $urandom & 32'hFFFF_FFFC;
    for (int i = 0; i < 3000; i++) begin
      tick;
      rst       = ($urandom_range(0, 199) == 0);
      ecall     = ($urandom_range(0, 15) == 0);
      ebreak    = ($urandom_range(0, 15) == 1);
      mret      = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 11) == 0) irq = ~irq;
      ex_we     = ($urandom_range(0, 2) == 0);
      inst_addr = $urandom & 32'hFFFF_FFFC;
    end
    tick; rst = 0; ecall = 0; ebreak = 0; mret = 0; irq = 0; ex_we = 0;
    repeat (8) tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
